envelope_sequencer: RTL
=======================

ENVELOPE_SEQUENCER -- requirements
Module: envelope_sequencer

Interface
REQ-001 Parameter ATTACK_STEP, default 16'd8192, gain increment per accepted sample in ATTACK (unsigned Q0.15).
REQ-002 Parameter DECAY_STEP, default 16'd4096, gain decrement per accepted sample in DECAY.
REQ-003 Parameter SUSTAIN_LEVEL, default 16'd16384, gain held in SUSTAIN; legal range 0..32767.
REQ-004 Parameter RELEASE_STEP, default 16'd2048, gain decrement per accepted sample in RELEASE.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 note_on  input  1  single-cycle key-press event.
REQ-008 note_off  input  1  single-cycle key-release event.
REQ-009 sample_in  input  16  signed oscillator sample, valid when in_ready=1.
REQ-010 in_ready  input  1  one-cycle strobe: sample_in valid, accept it.
REQ-011 sample_out  output  16  signed enveloped sample.
REQ-012 out_ready  output  1  one-cycle strobe: sample_out valid.
REQ-013 phase  output  3  current state encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-014 gain  output  15  current envelope gain, 0..32767 (Q0.15, 32767 ~ 1.0).

Function
REQ-015 States IDLE, ATTACK, DECAY, SUSTAIN, RELEASE; gain changes only on cycles with in_ready=1 and no event.
REQ-016 IDLE: gain=0; note_on -> ATTACK next cycle.
REQ-017 ATTACK: per accepted sample gain=min(gain+ATTACK_STEP, 32767), 16-bit intermediate; on reaching 32767 -> DECAY.
REQ-018 DECAY: per accepted sample gain=max(gain-DECAY_STEP, SUSTAIN_LEVEL), no underflow; on reaching SUSTAIN_LEVEL -> SUSTAIN.
REQ-019 SUSTAIN: gain held; no step.
REQ-020 RELEASE: per accepted sample gain=max(gain-RELEASE_STEP, 0); on reaching 0 -> IDLE.
REQ-021 note_off in ATTACK, DECAY or SUSTAIN -> RELEASE from current gain; ignored in IDLE and RELEASE.
REQ-022 note_on in any state, incl. RELEASE and ATTACK -> ATTACK retrigger from current gain (no reset to 0).
REQ-023 note_on and note_off in same cycle: note_on wins, note_off discarded.
REQ-024 Cycle with event and in_ready=1: sample still scaled and emitted with pre-event gain; gain does not step that cycle.
REQ-025 sample_out = (sample_in * gain) >>> 15, signed 16x16 (gain zero-extended) -> 32-bit product, arithmetic shift, truncated to 16 bits; no overflow possible.
REQ-026 Scaling uses gain value before that cycle's step.
REQ-027 Latency fixed: out_ready asserted exactly one cycle after in_ready, sample_out registered and held until next out_ready.
REQ-028 Back-to-back in_ready each cycle sustained at full throughput; no stall, no backpressure.
REQ-029 note_on/note_off while in_ready=0 take effect next cycle regardless of sample timing.
REQ-030 If DECAY reached with SUSTAIN_LEVEL=32767, transition to SUSTAIN on first DECAY sample with gain unchanged.

Reset
REQ-031 reset=0 asynchronously forces phase=IDLE, gain=0, sample_out=0, out_ready=0.
REQ-032 Reset asserted mid-note aborts envelope; after release, first in_ready yields sample_out=0 and events are accepted on first cycle after deassertion.

Structure
REQ-033 Shared package envelope_pkg holds state encodings (IDLE..RELEASE), GAIN_MAX=32767, GAIN_FRAC_BITS=15.
REQ-034 Scaling datapath (multiply, shift, output register, out_ready) is one sub-module gain_scaler; FSM and gain arithmetic stay in envelope_sequencer.

Verification (defaults)
REQ-035 reset low, then note_on, 4 strobes of sample_in=16'h7FFF -> gain 8192,16384,24576,32767, phase DECAY; 2nd sample_out=16'h1FFF.
REQ-036 Continue strobes -> gain 28671,24575,20479,16384 then phase SUSTAIN; further strobes keep gain=16384, sample_out=16'h3FFF for input 16'h7FFF.
REQ-037 From SUSTAIN, note_off, 8 strobes -> gain 14336..0 stepping 2048, then phase IDLE; sample_in=16'h8000 at gain 0 -> sample_out=0.
REQ-038 note_off mid-ATTACK at gain 16384, then note_on during RELEASE at gain 12288 -> ATTACK resumes at 12288, next strobe 20480.
REQ-039 note_on and note_off same cycle with in_ready=1 in SUSTAIN -> phase ATTACK, gain unchanged that cycle, out_ready next cycle.
REQ-040 reset pulled low asynchronously mid-RELEASE between clock edges -> phase, gain, out_ready 0 immediately.

Source files
------------

// File: rtl/envelope_pkg.sv
`default_nettype none
// ============================================================================
// Module      : envelope_pkg
// Description : Shared envelope state encodings and gain format constants.
// Revision    : 1.0 - initial release
// ============================================================================
package envelope_pkg;

    // Phase encoding, also visible on the phase output
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_e;

    // Gain is unsigned Q0.15; full scale is just under 1.0
    localparam logic [14:0] GAIN_MAX       = 15'd32767;
    localparam int          GAIN_FRAC_BITS = 15;

endpackage : envelope_pkg
`default_nettype wire

// File: rtl/gain_scaler.sv
`default_nettype none
// ============================================================================
// Module      : gain_scaler
// Description : Registered sample scaler: (sample * gain) >>> 15, one-cycle
//               latency, output held between strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module gain_scaler
    import envelope_pkg::*;
(
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [15:0] i_sample,
    input  logic [14:0] i_gain,
    output logic [15:0] o_sample,
    output logic        o_valid
);

    logic signed [31:0] w_product;
    logic        [15:0] r_sample;
    logic               r_valid;

    // Gain is zero-extended so it is always treated as non-negative
    assign w_product = $signed(i_sample) * $signed({1'b0, i_gain});

    // Capture the scaled sample on each strobe; hold it otherwise
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sample <= 16'd0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_sample <= 16'(w_product >>> GAIN_FRAC_BITS);
            end
        end
    end

    assign o_sample = r_sample;
    assign o_valid  = r_valid;

endmodule : gain_scaler
`default_nettype wire

// File: rtl/envelope_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : envelope_sequencer
// Description : ADSR envelope FSM with per-sample gain stepping, driving a
//               registered sample scaler.
// Revision    : 1.0 - initial release
// ============================================================================
module envelope_sequencer
    import envelope_pkg::*;
#(
    parameter logic [15:0] ATTACK_STEP   = 16'd8192,
    parameter logic [15:0] DECAY_STEP    = 16'd4096,
    parameter logic [15:0] SUSTAIN_LEVEL = 16'd16384,
    parameter logic [15:0] RELEASE_STEP  = 16'd2048
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        note_on,
    input  logic        note_off,
    input  logic [15:0] sample_in,
    input  logic        in_ready,
    output logic [15:0] sample_out,
    output logic        out_ready,
    output logic [2:0]  phase,
    output logic [14:0] gain
);

    env_state_e  r_state;
    env_state_e  w_state_nxt;
    logic [14:0] r_gain;
    logic [14:0] w_gain_nxt;

    logic [16:0] w_attack_sum;
    logic [15:0] w_decay_dn;
    logic [15:0] w_release_dn;
    logic        w_off_legal;

    // Candidate step results; subtractions clamp at zero instead of wrapping
    assign w_attack_sum = {2'b00, r_gain} + {1'b0, ATTACK_STEP};
    assign w_decay_dn   = ({1'b0, r_gain} >= DECAY_STEP)   ? ({1'b0, r_gain} - DECAY_STEP)   : 16'd0;
    assign w_release_dn = ({1'b0, r_gain} >= RELEASE_STEP) ? ({1'b0, r_gain} - RELEASE_STEP) : 16'd0;

    // note_off only matters while a note is sounding and not yet releasing
    assign w_off_legal = (r_state == ATTACK) || (r_state == DECAY) || (r_state == SUSTAIN);

    // Next state and gain: events take priority and freeze the gain that cycle
    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        if (note_on) begin
            w_state_nxt = ATTACK;
        end else if (note_off && w_off_legal) begin
            w_state_nxt = RELEASE;
        end else if (in_ready) begin
            case (r_state)
                IDLE: begin
                    w_gain_nxt = 15'd0;
                end
                ATTACK: begin
                    if (w_attack_sum >= {2'b00, GAIN_MAX}) begin
                        w_gain_nxt  = GAIN_MAX;
                        w_state_nxt = DECAY;
                    end else begin
                        w_gain_nxt = w_attack_sum[14:0];
                    end
                end
                DECAY: begin
                    if (w_decay_dn <= SUSTAIN_LEVEL) begin
                        w_gain_nxt  = SUSTAIN_LEVEL[14:0];
                        w_state_nxt = SUSTAIN;
                    end else begin
                        w_gain_nxt = w_decay_dn[14:0];
                    end
                end
                SUSTAIN: begin
                    w_gain_nxt = r_gain;
                end
                RELEASE: begin
                    w_gain_nxt = w_release_dn[14:0];
                    if (w_release_dn == 16'd0) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_gain_nxt  = 15'd0;
                end
            endcase
        end
    end

    // State and gain registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_gain  <= 15'd0;
        end else begin
            r_state <= w_state_nxt;
            r_gain  <= w_gain_nxt;
        end
    end

    // Scaling uses the pre-step gain of the cycle the sample arrives
    gain_scaler u_gain_scaler (
        .clk      (clk),
        .i_rst_n  (reset),
        .i_valid  (in_ready),
        .i_sample (sample_in),
        .i_gain   (r_gain),
        .o_sample (sample_out),
        .o_valid  (out_ready)
    );

    assign phase = r_state;
    assign gain  = r_gain;

endmodule : envelope_sequencer
`default_nettype wire
